// File: rtl/io_bank_arbiter.sv
// io_bank_arbiter: Wishbone-programmed user IO bank with LA takeover.
// Ports: wb_clk_i/wb_rst_ni (async low reset), wbs_* Wishbone slave,
//   la_req_i/la_gnt_o ownership handshake, la_out_i/la_oeb_i LA pad
//   drive, io_in/io_out/io_oeb pads, irq_o pulse on ownership change.
// Optional: define IO_IN_SYNC_EN to put a 2-flop synchronizer on io_in.
// Map: 00/04 OUT, 08/0C OEB, 10/14 IN, 18 CTRL{owned,allow}, 1C STATUS.
module io_bank_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          IO_W      = 38,
  parameter int          GUARD_CYC = 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic [31:0]     wbs_dat_o,
  output logic            wbs_ack_o,
  input  logic            la_req_i,
  output logic            la_gnt_o,
  input  logic [IO_W-1:0] la_out_i,
  input  logic [IO_W-1:0] la_oeb_i,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb,
  output logic            irq_o
);

  typedef enum logic [1:0] {
    WB_OWN      = 2'd0,
    GUARD_TO_LA = 2'd1,
    LA_OWN      = 2'd2,
    GUARD_TO_WB = 2'd3
  } own_e;

  localparam logic [3:0] GLOAD = 4'(GUARD_CYC - 1);

  own_e            st_q, st_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IO_W-1:0] out_q, oeb_q, in_q;
  logic [IO_W-1:0] pad_out_q, pad_oeb_q;
  logic [IO_W-1:0] out_w, oeb_w;
  logic            allow_q, gnt_q, irq_q, ack_q;
  logic [31:0]     dat_q, rdata;
  logic [63:0]     out64, oeb64, in64;
  logic            hit, acc, wr;
  logic [2:0]      widx;

  function automatic logic [63:0] wmerge(
    input logic [63:0] old,
    input logic [31:0] d,
    input logic [3:0]  sel,
    input logic        hi
  );
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        if (hi) r[32+8*b +: 8] = d[8*b +: 8];
        else    r[8*b +: 8]    = d[8*b +: 8];
      end
    end
    return r;
  endfunction

  // Misaligned word addresses decode as unmapped.
  assign hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8])
             && (wbs_adr_i[7:5] == 3'b000)
             && (wbs_adr_i[1:0] == 2'b00);
  assign widx = wbs_adr_i[4:2];

  // A new access is only taken while ack is low, which spaces
  // back-to-back accesses two cycles apart.
  assign acc = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr  = ack_q & wbs_cyc_i & wbs_stb_i & wbs_we_i & hit;

  assign out64 = 64'(out_q);
  assign oeb64 = 64'(oeb_q);
  assign in64  = 64'(in_q);
  assign out_w = IO_W'(wmerge(out64, wbs_dat_i, wbs_sel_i, widx[0]));
  assign oeb_w = IO_W'(wmerge(oeb64, wbs_dat_i, wbs_sel_i, widx[0]));

  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (widx)
        3'd0: rdata = out64[31:0];
        3'd1: rdata = out64[63:32];
        3'd2: rdata = oeb64[31:0];
        3'd3: rdata = oeb64[63:32];
        3'd4: rdata = in64[31:0];
        3'd5: rdata = in64[63:32];
        3'd6: rdata = {30'd0, gnt_q, allow_q};
        3'd7: rdata = {30'd0, st_q};
      endcase
    end
  end

  // An abandoned cycle never shows an ack or its data.
  assign wbs_ack_o = ack_q & wbs_cyc_i & wbs_stb_i;
  assign wbs_dat_o = wbs_ack_o ? dat_q : '0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc && !wbs_we_i) ? rdata : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_q   <= '0;
      oeb_q   <= '1;
      allow_q <= 1'b0;
    end else if (wr) begin
      case (widx)
        3'd0, 3'd1: out_q <= out_w;
        3'd2, 3'd3: oeb_q <= oeb_w;
        3'd6: if (wbs_sel_i[0]) allow_q <= wbs_dat_i[0];
        default: ;
      endcase
    end
  end

`ifdef IO_IN_SYNC_EN
  logic [IO_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      in_q    <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      in_q    <= sync2_q;
    end
  end
`else
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) in_q <= '0;
    else            in_q <= io_in;
  end
`endif

  // Guard states ignore la_req_i; LA_OWN hands back as soon as either
  // the request or the permission goes away.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      WB_OWN: begin
        if (la_req_i && allow_q) begin
          st_d  = GUARD_TO_LA;
          cnt_d = GLOAD;
        end
      end
      GUARD_TO_LA: begin
        if (cnt_q == 4'd0) st_d = LA_OWN;
        else               cnt_d = cnt_q - 4'd1;
      end
      LA_OWN: begin
        if (!la_req_i || !allow_q) begin
          st_d  = GUARD_TO_WB;
          cnt_d = GLOAD;
        end
      end
      GUARD_TO_WB: begin
        if (cnt_q == 4'd0) st_d = WB_OWN;
        else               cnt_d = cnt_q - 4'd1;
      end
    endcase
  end

  // Pads are registered from the next state so the tristate window
  // coincides exactly with the guard states.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      st_q      <= WB_OWN;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      irq_q     <= 1'b0;
      pad_out_q <= '0;
      pad_oeb_q <= '1;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      gnt_q <= (st_d == LA_OWN);
      irq_q <= ((st_d == LA_OWN) && (st_q == GUARD_TO_LA))
            || ((st_d == WB_OWN) && (st_q == GUARD_TO_WB));
      unique case (st_d)
        WB_OWN: begin
          pad_out_q <= out_q;
          pad_oeb_q <= oeb_q;
        end
        LA_OWN: begin
          pad_out_q <= la_out_i;
          pad_oeb_q <= la_oeb_i;
        end
        default: pad_oeb_q <= '1;
      endcase
    end
  end

  assign la_gnt_o = gnt_q;
  assign irq_o    = irq_q;
  assign io_out   = pad_out_q;
  assign io_oeb   = pad_oeb_q;

endmodule

// File: tb/tb_io_bank_arbiter.sv
// Bench for io_bank_arbiter: register table, handshake sequences,
// async reset, and randomized LA traffic against a reference model.
module tb_io_bank_arbiter;
  localparam int          IO_W      = 38;
  localparam int          GUARD_CYC = 1;
  localparam logic [31:0] BASE      = 32'h3000_0000;
`ifdef IO_IN_SYNC_EN
  localparam int IN_LAT = 3;
`else
  localparam int IN_LAT = 1;
`endif
  localparam logic [IO_W-1:0] ALL1 = '1;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_ni = 1'b1;
  logic            wbs_cyc_i = 1'b0;
  logic            wbs_stb_i = 1'b0;
  logic            wbs_we_i = 1'b0;
  logic [3:0]      wbs_sel_i = '0;
  logic [31:0]     wbs_adr_i = '0;
  logic [31:0]     wbs_dat_i = '0;
  logic [31:0]     wbs_dat_o;
  logic            wbs_ack_o;
  logic            la_req_i = 1'b0;
  logic            la_gnt_o;
  logic [IO_W-1:0] la_out_i = '0;
  logic [IO_W-1:0] la_oeb_i = '1;
  logic [IO_W-1:0] io_in = '0;
  logic [IO_W-1:0] io_out;
  logic [IO_W-1:0] io_oeb;
  logic            irq_o;

  io_bank_arbiter #(
    .BASE_ADDR(BASE),
    .IO_W(IO_W),
    .GUARD_CYC(GUARD_CYC)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o),
    .la_req_i(la_req_i),
    .la_gnt_o(la_gnt_o),
    .la_out_i(la_out_i),
    .la_oeb_i(la_oeb_i),
    .io_in(io_in),
    .io_out(io_out),
    .io_oeb(io_oeb),
    .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int errors = 0;
  int checks = 0;

  // Register shadow, updated when a write completes.
  logic [IO_W-1:0] mod_out, mod_oeb;
  logic            mod_allow;

  // Ownership model: owner vs. wanted owner, with a guard countdown.
  logic            m_owner, m_target;
  int              m_guard;
  logic            exp_gnt, exp_irq;
  logic [IO_W-1:0] exp_out, exp_oeb;

  always @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      m_owner  <= 1'b0;
      m_target <= 1'b0;
      m_guard  <= 0;
      exp_gnt  <= 1'b0;
      exp_irq  <= 1'b0;
      exp_out  <= '0;
      exp_oeb  <= '1;
    end else if (m_guard > 0) begin
      m_guard <= m_guard - 1;
      exp_irq <= 1'b0;
      if (m_guard == 1) begin
        m_owner <= m_target;
        exp_irq <= 1'b1;
        exp_gnt <= m_target;
        exp_out <= m_target ? la_out_i : mod_out;
        exp_oeb <= m_target ? la_oeb_i : mod_oeb;
      end
    end else if (m_owner != (la_req_i && mod_allow)) begin
      m_guard  <= GUARD_CYC;
      m_target <= ~m_owner;
      exp_gnt  <= 1'b0;
      exp_irq  <= 1'b0;
      exp_oeb  <= '1;
    end else begin
      exp_irq <= 1'b0;
      exp_gnt <= m_owner;
      exp_out <= m_owner ? la_out_i : mod_out;
      exp_oeb <= m_owner ? la_oeb_i : mod_oeb;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk_i);
    chk("pad_gnt", la_gnt_o, exp_gnt);
    chk("pad_irq", irq_o, exp_irq);
    chk("pad_out", io_out, exp_out);
    chk("pad_oeb", io_oeb, exp_oeb);
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    logic [63:0] t;
    int          sh;
    if (a[31:8] == BASE[31:8] && a[1:0] == 2'b00) begin
      sh = a[2] ? 32 : 0;
      t  = (a[7:0] == 8'h00 || a[7:0] == 8'h04) ? 64'(mod_out)
                                                 : 64'(mod_oeb);
      for (int b = 0; b < 4; b++)
        if (s[b]) t[sh+8*b +: 8] = d[8*b +: 8];
      case (a[7:0])
        8'h00, 8'h04: mod_out = t[IO_W-1:0];
        8'h08, 8'h0C: mod_oeb = t[IO_W-1:0];
        8'h18: if (s[0]) mod_allow = d[0];
        default: ;
      endcase
    end
  endtask

  task automatic wb_access(input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = a;
    wbs_dat_i = d;
    wbs_sel_i = s;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (wbs_ack_o) begin
        got = 1'b1;
        rd  = wbs_dat_o;
      end
    end
    chk("ack_seen", got, 1'b1);
    @(posedge wb_clk_i);
    #1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (we && got) model_write(a, d, s);
  endtask

  task automatic do_reset();
    wb_rst_ni = 1'b0;
    mod_out   = '0;
    mod_oeb   = '1;
    mod_allow = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[22];
  logic [31:0] rd;
  logic [63:0] w;
  int unsigned r;

  initial begin
    tbl[0]  = '{1'b0, BASE + 32'h08, 32'h0, 4'hF, 32'hFFFF_FFFF};
    tbl[1]  = '{1'b0, BASE + 32'h0C, 32'h0, 4'hF, 32'h0000_003F};
    tbl[2]  = '{1'b0, BASE + 32'h1C, 32'h0, 4'hF, 32'h0};
    tbl[3]  = '{1'b0, BASE + 32'h18, 32'h0, 4'hF, 32'h0};
    tbl[4]  = '{1'b0, BASE + 32'h00, 32'h0, 4'hF, 32'h0};
    tbl[5]  = '{1'b1, BASE + 32'h00, 32'hA5A5_0F0F, 4'b0011, 32'h0};
    tbl[6]  = '{1'b0, BASE + 32'h00, 32'h0, 4'hF, 32'h0000_0F0F};
    tbl[7]  = '{1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[8]  = '{1'b0, BASE + 32'h04, 32'h0, 4'hF, 32'h0000_003F};
    tbl[9]  = '{1'b1, BASE + 32'h08, 32'h1234_5678, 4'b1100, 32'h0};
    tbl[10] = '{1'b0, BASE + 32'h08, 32'h0, 4'hF, 32'h1234_FFFF};
    tbl[11] = '{1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[12] = '{1'b0, BASE + 32'h20, 32'h0, 4'hF, 32'h0};
    tbl[13] = '{1'b1, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[14] = '{1'b0, BASE + 32'h00, 32'h0, 4'hF, 32'h0000_0F0F};
    tbl[15] = '{1'b0, BASE + 32'h100, 32'h0, 4'hF, 32'h0};
    tbl[16] = '{1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[17] = '{1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'h0};
    tbl[18] = '{1'b1, BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[19] = '{1'b0, BASE + 32'h18, 32'h0, 4'hF, 32'h1};
    tbl[20] = '{1'b1, BASE + 32'h18, 32'h0, 4'hF, 32'h0};
    tbl[21] = '{1'b0, BASE + 32'h18, 32'h0, 4'hF, 32'h0};

    do_reset();
    chk("rst_oeb", io_oeb, ALL1);
    chk("rst_out", io_out, '0);
    chk("rst_gnt", la_gnt_o, 1'b0);
    chk("rst_ack", wbs_ack_o, 1'b0);
    tick();

    for (int i = 0; i < 22; i++) begin
      wb_access(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
      chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
      tick();
    end

    // Held strobe: ack every other cycle, data only with ack.
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = BASE;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ack_pat", wbs_ack_o, (i % 2 == 0));
      chk("ack_dat", wbs_dat_o, (i % 2 == 0) ? 32'h0F0F : 32'h0);
    end
    @(posedge wb_clk_i);
    #1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    tick();
    tick();

    // Cycle abandoned during the ack cycle: no ack, no write.
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_adr_i = BASE;
    wbs_dat_i = 32'hFFFF_FFFF;
    wbs_sel_i = 4'hF;
    tick();
    chk("drop_pre_ack", wbs_ack_o, 1'b1);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    #1;
    chk("drop_ack", wbs_ack_o, 1'b0);
    tick();
    tick();
    wb_access(1'b0, BASE, 32'h0, 4'hF, rd);
    chk("drop_nowrite", rd, 32'h0000_0F0F);
    tick();

    // Input readback and latency.
    io_in = 38'h2A_DEAD_BEEF;
    repeat (4) tick();
    wb_access(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd);
    chk("in_lo", rd, 32'hDEAD_BEEF);
    tick();
    wb_access(1'b0, BASE + 32'h14, 32'h0, 4'hF, rd);
    chk("in_hi", rd, 32'h0000_002A);
    tick();
    io_in = 38'h01_1111_1111;
    wb_access(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd);
    chk("in_lat_old", rd, 32'hDEAD_BEEF);
    tick();
    io_in = 38'h02_2222_2222;
    repeat (IN_LAT) tick();
    wb_access(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd);
    chk("in_lat_new", rd, 32'h2222_2222);
    tick();
    io_in = 38'h03_3333_3333;
    repeat (IN_LAT - 1) tick();
    wb_access(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd);
    chk("in_lat_edge", rd, 32'h2222_2222);
    tick();

    // LA takeover.
    wb_access(1'b1, BASE + 32'h18, 32'h1, 4'hF, rd);
    tick();
    la_out_i = 38'h15_5555_5555;
    la_oeb_i = '0;
    la_req_i = 1'b1;
    tick();
    chk("hs_g_gnt", la_gnt_o, 1'b0);
    chk("hs_g_oeb", io_oeb, ALL1);
    chk("hs_g_out", io_out, 38'h3F_0000_0F0F);
    chk("hs_g_irq", irq_o, 1'b0);
    tick();
    chk("hs_la_gnt", la_gnt_o, 1'b1);
    chk("hs_la_irq", irq_o, 1'b1);
    chk("hs_la_out", io_out, 38'h15_5555_5555);
    chk("hs_la_oeb", io_oeb, '0);
    tick();
    chk("hs_irq_once", irq_o, 1'b0);
    wb_access(1'b0, BASE + 32'h1C, 32'h0, 4'hF, rd);
    chk("hs_status", rd, 32'h2);
    tick();
    wb_access(1'b0, BASE + 32'h18, 32'h0, 4'hF, rd);
    chk("hs_ctrl", rd, 32'h3);
    tick();
    wb_access(1'b1, BASE, 32'h1111_2222, 4'hF, rd);
    tick();
    chk("hs_la_hold", io_out, 38'h15_5555_5555);

    // LA release.
    la_req_i = 1'b0;
    tick();
    chk("rel_gnt", la_gnt_o, 1'b0);
    chk("rel_oeb", io_oeb, ALL1);
    chk("rel_out", io_out, 38'h15_5555_5555);
    tick();
    chk("rel_irq", irq_o, 1'b1);
    chk("rel_wb_oeb", io_oeb, 38'h3F_1234_FFFF);
    chk("rel_wb_out", io_out, 38'h3F_1111_2222);
    tick();
    chk("rel_irq_end", irq_o, 1'b0);
    wb_access(1'b0, BASE + 32'h1C, 32'h0, 4'hF, rd);
    chk("rel_status", rd, 32'h0);
    tick();

    // Asynchronous reset while the LA owns the pads.
    la_req_i = 1'b1;
    repeat (3) tick();
    chk("rst_pre_gnt", la_gnt_o, 1'b1);
    wb_rst_ni = 1'b0;
    mod_out   = '0;
    mod_oeb   = '1;
    mod_allow = 1'b0;
    #1;
    chk("arst_gnt", la_gnt_o, 1'b0);
    chk("arst_oeb", io_oeb, ALL1);
    chk("arst_out", io_out, '0);
    tick();
    la_req_i = 1'b0;
    tick();
    wb_rst_ni = 1'b1;
    tick();
    wb_access(1'b0, BASE + 32'h18, 32'h0, 4'hF, rd);
    chk("arst_ctrl", rd, 32'h0);
    tick();
    wb_access(1'b0, BASE + 32'h08, 32'h0, 4'hF, rd);
    chk("arst_oeb_reg", rd, 32'hFFFF_FFFF);
    tick();
    wb_access(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd);
    chk("arst_out_reg", rd, 32'h0);
    tick();

    // Random LA traffic and register writes against the model.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        wb_access(1'b1, BASE + 32'h18,
                  {31'd0, ($urandom_range(0, 3) != 0)}, 4'hF, rd);
        tick();
      end else if (r == 1) begin
        wb_access(1'b1, BASE + 32'(4 * $urandom_range(0, 3)),
                  $urandom, 4'($urandom), rd);
        tick();
      end else begin
        if ($urandom_range(0, 3) == 0) la_req_i = ~la_req_i;
        w = {$urandom, $urandom};
        la_out_i = w[IO_W-1:0];
        w = {$urandom, $urandom};
        la_oeb_i = w[IO_W-1:0];
        tick();
      end
    end
    la_req_i = 1'b0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
